dsp_mac_sequencer: RTL and testbench

Initiator-side controller for the team's pipelined DSP multiply-accumulate slice. It accepts a dot-product job (vector length), streams operand pairs from a valid/ready source into the slice, drains the slice pipeline and returns the dot-product result on a valid/ready result port. The slice accumulator has no clear, so the sequencer keeps a baseline snapshot and reports the per-job difference.

---
 rtl/dsp_mac_sequencer_pkg.sv | 22 ++
 rtl/dsp_mac_sequencer.sv | 152 +++++++++++++++
 tb/tb_dsp_mac_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_mac_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dsp_mac_sequencer_pkg
// Brief    : Shared state encoding and slice timing constants for the
//            DSP MAC sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package dsp_mac_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned MAC_LATENCY  = 3;
    // Operand register stage plus slice latency.
    localparam int unsigned DRAIN_CYCLES = MAC_LATENCY + 1;

endpackage
`default_nettype wire

// File: rtl/dsp_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dsp_mac_sequencer
// Brief    : Streams dot-product jobs into a pipelined MAC slice and returns
//            the per-job accumulator delta on a valid/ready result port.
// Revision : 1.0 - initial release
// ============================================================================
module dsp_mac_sequencer
    import dsp_mac_sequencer_pkg::*;
#(
    parameter int WIDTH_OP1 = 18,
    parameter int WIDTH_OP2 = 18,
    parameter int WIDTH_OUT = 48,
    parameter int CNT_W     = 16
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 CMD_VALID,
    output logic                 CMD_READY,
    input  logic [CNT_W-1:0]     CMD_LEN,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [WIDTH_OP1-1:0] IN_A,
    input  logic [WIDTH_OP2-1:0] IN_B,
    output logic                 RES_VALID,
    input  logic                 RES_READY,
    output logic [WIDTH_OUT-1:0] RES_DATA,
    output logic                 BUSY,
    output logic                 MAC_EN,
    output logic                 MAC_ACC_EN,
    output logic [WIDTH_OP1-1:0] MAC_OP1,
    output logic [WIDTH_OP2-1:0] MAC_OP2,
    input  logic [WIDTH_OUT-1:0] MAC_OUT
);

    localparam logic [CNT_W-1:0] C_DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE    = CNT_W'(1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [WIDTH_OUT-1:0]   r_base;
    logic [WIDTH_OUT-1:0]   r_res;
    logic [WIDTH_OP1-1:0]   r_op1;
    logic [WIDTH_OP2-1:0]   r_op2;
    logic                   r_acc_en;
    logic                   r_mac_en;

    logic                   w_cmd_ready;
    logic                   w_in_ready;
    logic                   w_res_valid;
    logic                   w_cmd_hs;
    logic                   w_in_hs;
    logic                   w_res_hs;
    logic                   w_cnt_last;
    logic                   w_drain_done;

    always_comb begin
        w_state_nxt  = r_state;
        // r_mac_en doubles as "out of reset" so CMD_READY stays low in reset.
        w_cmd_ready  = (r_state == ST_IDLE) && r_mac_en;
        w_in_ready   = (r_state == ST_RUN);
        w_res_valid  = (r_state == ST_DONE);
        w_cmd_hs     = CMD_VALID && w_cmd_ready;
        w_in_hs      = IN_VALID && w_in_ready;
        w_res_hs     = RES_READY && w_res_valid;
        w_cnt_last   = (r_cnt == C_CNT_ONE);
        w_drain_done = (r_cnt == '0);

        unique case (r_state)
            ST_IDLE: begin
                if (w_cmd_hs) begin
                    w_state_nxt = (CMD_LEN == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_in_hs && w_cnt_last) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_drain_done) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (w_res_hs) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_base   <= '0;
            r_res    <= '0;
            r_op1    <= '0;
            r_op2    <= '0;
            r_acc_en <= 1'b0;
            r_mac_en <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_mac_en <= 1'b1;
            r_acc_en <= w_in_hs;
            r_op1    <= w_in_hs ? IN_A : '0;
            r_op2    <= w_in_hs ? IN_B : '0;

            unique case (r_state)
                ST_IDLE: begin
                    if (w_cmd_hs) begin
                        r_cnt <= CMD_LEN;
                        if (CMD_LEN == '0) begin
                            r_res <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_in_hs) begin
                        // Counter is reused as the drain timer once the last pair is in.
                        r_cnt <= w_cnt_last ? C_DRAIN_LOAD : r_cnt - C_CNT_ONE;
                    end
                end
                ST_DRAIN: begin
                    if (w_drain_done) begin
                        r_res  <= MAC_OUT - r_base;
                        r_base <= MAC_OUT;
                    end else begin
                        r_cnt  <= r_cnt - C_CNT_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign CMD_READY  = w_cmd_ready;
    assign IN_READY   = w_in_ready;
    assign RES_VALID  = w_res_valid;
    assign RES_DATA   = r_res;
    assign BUSY       = (r_state != ST_IDLE);
    assign MAC_EN     = r_mac_en;
    assign MAC_ACC_EN = r_acc_en;
    assign MAC_OP1    = r_op1;
    assign MAC_OP2    = r_op2;

endmodule
`default_nettype wire

// File: tb/tb_dsp_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsp_mac_sequencer
// Brief    : Directed scoreboard bench with a behavioural MAC slice model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dsp_mac_sequencer;

    localparam int WIDTH_OP1 = 18;
    localparam int WIDTH_OP2 = 18;
    localparam int WIDTH_OUT = 48;
    localparam int CNT_W     = 16;

    logic                 CLK = 1'b0;
    logic                 RSTN;
    logic                 CMD_VALID;
    logic                 CMD_READY;
    logic [CNT_W-1:0]     CMD_LEN;
    logic                 IN_VALID;
    logic                 IN_READY;
    logic [WIDTH_OP1-1:0] IN_A;
    logic [WIDTH_OP2-1:0] IN_B;
    logic                 RES_VALID;
    logic                 RES_READY;
    logic [WIDTH_OUT-1:0] RES_DATA;
    logic                 BUSY;
    logic                 MAC_EN;
    logic                 MAC_ACC_EN;
    logic [WIDTH_OP1-1:0] MAC_OP1;
    logic [WIDTH_OP2-1:0] MAC_OP2;
    logic [WIDTH_OUT-1:0] MAC_OUT;

    dsp_mac_sequencer #(
        .WIDTH_OP1 (WIDTH_OP1),
        .WIDTH_OP2 (WIDTH_OP2),
        .WIDTH_OUT (WIDTH_OUT),
        .CNT_W     (CNT_W)
    ) dut (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .CMD_VALID  (CMD_VALID),
        .CMD_READY  (CMD_READY),
        .CMD_LEN    (CMD_LEN),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .IN_A       (IN_A),
        .IN_B       (IN_B),
        .RES_VALID  (RES_VALID),
        .RES_READY  (RES_READY),
        .RES_DATA   (RES_DATA),
        .BUSY       (BUSY),
        .MAC_EN     (MAC_EN),
        .MAC_ACC_EN (MAC_ACC_EN),
        .MAC_OP1    (MAC_OP1),
        .MAC_OP2    (MAC_OP2),
        .MAC_OUT    (MAC_OUT)
    );

    always #5 CLK = ~CLK;

    // Slice model: operands at t land in the accumulator on the edge ending t+2.
    logic [WIDTH_OUT-1:0] m_acc = '0;
    logic [WIDTH_OUT-1:0] m_p1  = '0;
    logic [WIDTH_OUT-1:0] m_p2  = '0;
    logic                 m_e1  = 1'b0;
    logic                 m_e2  = 1'b0;

    always @(posedge CLK) begin
        if (MAC_EN || !RSTN) begin
            m_p1 <= WIDTH_OUT'($signed(MAC_OP1) * $signed(MAC_OP2));
            m_p2 <= m_p1;
            m_e1 <= MAC_ACC_EN;
            m_e2 <= m_e1;
        end
        if (!RSTN)
            m_acc <= '0;
        else if (MAC_EN && m_e2)
            m_acc <= m_acc + m_p2;
    end
    assign MAC_OUT = m_acc;

    int cyc = 0;
    int acc_en_cnt = 0;
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (MAC_ACC_EN) acc_en_cnt <= acc_en_cnt + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [WIDTH_OUT-1:0] sb[$];
    int ja[$];
    int jb[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Drives the job in ja/jb; bubbles = idle cycles after each pair,
    // hold = cycles RES_READY stays low once the result is valid.
    task automatic run_job(input string name, input int bubbles, input int hold);
        int len;
        int t;
        int cmd_cyc;
        int last_k;
        int first;
        longint acc;
        logic [WIDTH_OUT-1:0] exp_res;
        logic [WIDTH_OUT-1:0] held;
        len = ja.size();
        acc = 0;
        for (int i = 0; i < len; i++) acc += longint'(ja[i]) * longint'(jb[i]);
        sb.push_back(acc[WIDTH_OUT-1:0]);

        t = 0;
        while (!CMD_READY && t < 20) begin step(); t++; end
        check({name, "_cmd_ready"}, 64'(CMD_READY), 64'd1);
        CMD_VALID = 1'b1;
        CMD_LEN   = CNT_W'(len);
        cmd_cyc   = cyc;
        step();
        CMD_VALID = 1'b0;
        last_k    = cmd_cyc;

        for (int i = 0; i < len; i++) begin
            IN_VALID = 1'b1;
            IN_A     = WIDTH_OP1'(ja[i]);
            IN_B     = WIDTH_OP2'(jb[i]);
            t = 0;
            while (!IN_READY && t < 20) begin step(); t++; end
            if (!IN_READY) check({name, "_in_ready_timeout"}, 64'(IN_READY), 64'd1);
            last_k = cyc;
            step();
            IN_VALID = 1'b0;
            IN_A     = '0;
            IN_B     = '0;
            for (int j = 0; j < bubbles; j++) step();
        end

        t = 0;
        while (!RES_VALID && t < 30) begin step(); t++; end
        check({name, "_res_valid"}, 64'(RES_VALID), 64'd1);
        first = cyc;
        if (len == 0)
            check({name, "_latency_len0"}, 64'(first), 64'(cmd_cyc + 1));
        else if (bubbles == 0)
            check({name, "_latency"}, 64'(first), 64'(last_k + 5));

        held = RES_DATA;
        for (int h = 0; h < hold; h++) begin
            check({name, "_hold_data"}, 64'(RES_DATA), 64'(held));
            check({name, "_hold_cmd_rdy"}, {CMD_READY, IN_READY, RES_VALID, BUSY}, 64'b0011);
            step();
        end

        RES_READY = 1'b1;
        exp_res = sb.pop_front();
        check({name, "_res_data"}, 64'(RES_DATA), 64'(exp_res));
        step();
        RES_READY = 1'b0;
        check({name, "_after_hs"}, {RES_VALID, CMD_READY, BUSY}, 64'b010);
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_ctl"}, {CMD_READY, IN_READY, RES_VALID, BUSY, MAC_EN, MAC_ACC_EN}, 64'd0);
        check({name, "_data"}, 64'(RES_DATA), 64'd0);
        check({name, "_ops"}, {MAC_OP1, MAC_OP2}, 64'd0);
    endtask

    initial begin
        int acc_snap;
        RSTN = 1'b0; CMD_VALID = 1'b0; CMD_LEN = '0; IN_VALID = 1'b0;
        IN_A = '0; IN_B = '0; RES_READY = 1'b0;

        step();
        check_reset_vals("rst_c1");
        step();
        step();
        check_reset_vals("rst_c3");
        RSTN = 1'b1;
        step();
        check("post_rst_cmd_ready", {CMD_READY, MAC_EN, BUSY}, 64'b110);

        ja = '{1, 2, 3, 4};         jb = '{5, 6, 7, 8};
        run_job("dot4", 0, 0);

        ja = '{3};                  jb = '{-4};
        run_job("jobA", 0, 0);
        ja = '{-2, 10};             jb = '{-2, 1};
        run_job("jobB", 0, 0);

        ja = '{-131072, -131072, -131072};
        jb = '{-131072, -131072, -131072};
        run_job("bubbles", 2, 0);

        ja = '{-7, 9};              jb = '{11, -13};
        run_job("stall", 0, 10);

        acc_snap = acc_en_cnt;
        ja = {};                    jb = {};
        run_job("len0", 0, 0);
        step();
        check("len0_no_acc_en", 64'(acc_en_cnt), 64'(acc_snap));

        // Abort a 5-pair job after two pairs; let the slice pipeline settle first.
        CMD_VALID = 1'b1;
        CMD_LEN   = CNT_W'(5);
        step();
        CMD_VALID = 1'b0;
        for (int i = 0; i < 2; i++) begin
            IN_VALID = 1'b1; IN_A = 18'd100; IN_B = 18'd100;
            step();
        end
        IN_VALID = 1'b0; IN_A = '0; IN_B = '0;
        repeat (4) step();
        check("abort_busy", {BUSY, IN_READY}, 64'b11);
        RSTN = 1'b0;
        step();
        check_reset_vals("abort_rst_c1");
        step();
        check_reset_vals("abort_rst_c2");
        RSTN = 1'b1;
        step();
        check("abort_post_rst", {CMD_READY, RES_VALID, BUSY, MAC_EN}, 64'b1001);
        repeat (6) begin
            check("abort_no_result", 64'(RES_VALID), 64'd0);
            step();
        end

        ja = '{7};                  jb = '{6};
        run_job("after_rst", 0, 0);

        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
